rgb_led_driver: RTL and testbench

- Consumer end of the 3-bit `colour` code produced by the button-driven lights sequencer.
- Converts each code into three PWM LED drive lines (red, green, blue).
- Fades each channel linearly toward its target brightness rather than switching abruptly.
- Sits between the lights sequencer and the board RGB LED pins.

---
 rtl/lights_pkg.sv | 17 +
 rtl/pwm_channel.sv | 45 ++++
 rtl/rgb_led_driver.sv | 99 +++++++++
 tb/tb_rgb_led_driver.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/lights_pkg.sv
// Shared definitions for the lights sequencer and its RGB LED consumer:
// colour code bit positions, named colour codes and the fade FSM encoding.
package lights_pkg;

    localparam int RED_BIT = 0;
    localparam int GRN_BIT = 1;
    localparam int BLU_BIT = 2;

    localparam logic [2:0] COL_OFF   = 3'b000;
    localparam logic [2:0] COL_WHITE = 3'b111;

    typedef enum logic {
        SETTLED = 1'b0,
        FADING  = 1'b1
    } fade_state_t;

endpackage : lights_pkg

// File: rtl/pwm_channel.sv
// One LED channel: brightness level that steps by one per fade tick toward
// full-on or full-off, and a registered PWM compare against the shared counter.
module pwm_channel
    import lights_pkg::*;
#(
    parameter int PWM_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic             enable,
    input  logic             target_bit,
    input  logic [PWM_W-1:0] pwm_cnt,
    output logic             led,
    output logic             level_eq_target
);

    localparam logic [PWM_W-1:0] MAX_LEVEL = '1;

    logic [PWM_W-1:0] r_level;
    logic             r_led;
    logic [PWM_W-1:0] w_target;

    assign w_target        = target_bit ? MAX_LEVEL : '0;
    assign level_eq_target = (r_level == w_target);
    assign led             = r_led;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_level <= '0;
            r_led   <= 1'b0;
        end else begin
            r_led <= enable && (pwm_cnt < r_level);
            // Targets are only ever 0 or MAX_LEVEL, so a unit step can never wrap.
            if (tick) begin
                if (r_level < w_target) begin
                    r_level <= r_level + PWM_W'(1);
                end else if (r_level > w_target) begin
                    r_level <= r_level - PWM_W'(1);
                end
            end
        end
    end

endmodule : pwm_channel

// File: rtl/rgb_led_driver.sv
// Turns the 3-bit colour code into three PWM LED drives that fade linearly
// toward their new brightness; owns the colour capture, timers and fade FSM.
module rgb_led_driver
    import lights_pkg::*;
#(
    parameter int PWM_W    = 8,
    parameter int FADE_DIV = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] colour,
    input  logic       enable,
    output logic       red,
    output logic       green,
    output logic       blue,
    output logic       fading
);

    localparam int              FC_W    = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam logic [FC_W-1:0] FC_LAST = FC_W'(FADE_DIV - 1);

    logic [2:0]       r_col_q;
    logic [PWM_W-1:0] r_pwm_cnt;
    logic [FC_W-1:0]  r_fade_cnt;
    fade_state_t      r_state;
    logic             r_fading;

    logic             w_tick;
    logic [2:0]       w_led;
    logic [2:0]       w_eq;
    logic             w_all_eq;

    // Fade timer freezes while blanked, so no ticks reach the channels.
    assign w_tick   = enable && (r_fade_cnt == FC_LAST);
    assign w_all_eq = &w_eq;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_q    <= COL_OFF;
            r_pwm_cnt  <= '0;
            r_fade_cnt <= '0;
        end else begin
            r_col_q   <= colour;
            r_pwm_cnt <= r_pwm_cnt + PWM_W'(1);
            if (enable) begin
                r_fade_cnt <= (r_fade_cnt == FC_LAST) ? '0 : r_fade_cnt + FC_W'(1);
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_chan
            pwm_channel #(
                .PWM_W (PWM_W)
            ) u_chan (
                .clk             (clk),
                .rst             (rst),
                .tick            (w_tick),
                .enable          (enable),
                .target_bit      (r_col_q[gi]),
                .pwm_cnt         (r_pwm_cnt),
                .led             (w_led[gi]),
                .level_eq_target (w_eq[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= SETTLED;
            r_fading <= 1'b0;
        end else begin
            case (r_state)
                SETTLED: begin
                    if (!w_all_eq) begin
                        r_state  <= FADING;
                        r_fading <= 1'b1;
                    end
                end
                FADING: begin
                    if (w_all_eq) begin
                        r_state  <= SETTLED;
                        r_fading <= 1'b0;
                    end
                end
                default: begin
                    r_state  <= SETTLED;
                    r_fading <= 1'b0;
                end
            endcase
        end
    end

    assign red    = w_led[RED_BIT];
    assign green  = w_led[GRN_BIT];
    assign blue   = w_led[BLU_BIT];
    assign fading = r_fading;

endmodule : rgb_led_driver

// File: tb/tb_rgb_led_driver.sv
// Scoreboard bench: a cycle-level behavioural model predicts the four outputs
// after every clock edge; a separate monitor compares them against the DUT.
module tb_rgb_led_driver;
    import lights_pkg::*;

    localparam int PWM_W    = 4;
    localparam int FADE_DIV = 2;
    localparam int MAXL     = (1 << PWM_W) - 1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] colour = 3'b000;
    logic       enable = 1'b0;
    logic       red, green, blue, fading;

    rgb_led_driver #(
        .PWM_W    (PWM_W),
        .FADE_DIV (FADE_DIV)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .colour (colour),
        .enable (enable),
        .red    (red),
        .green  (green),
        .blue   (blue),
        .fading (fading)
    );

    always #5 clk = ~clk;

    // {fading, blue, green, red}
    logic [3:0] exp_q[$];
    int checks = 0;
    int errors = 0;
    int cycle  = 0;

    // Reference model state: brightness per channel, captured colour,
    // cycle position within the PWM period, enabled cycles within a fade step.
    int m_lvl[3];
    int m_col;
    int m_pwm;
    int m_fc;

    task automatic step(input bit r, input bit [2:0] c, input bit e);
        logic [3:0] x;
        bit any_diff;
        bit tick;
        int tgt;
        @(negedge clk);
        rst = r; colour = c; enable = e;
        x = '0;
        if (r) begin
            for (int i = 0; i < 3; i++) m_lvl[i] = 0;
            m_col = 0; m_pwm = 0; m_fc = 0;
        end else begin
            any_diff = 1'b0;
            tick = e && (m_fc == FADE_DIV - 1);
            for (int i = 0; i < 3; i++) begin
                tgt = m_col[i] ? MAXL : 0;
                x[i] = e && (m_pwm < m_lvl[i]);
                if (m_lvl[i] != tgt) any_diff = 1'b1;
                if (tick && m_lvl[i] < tgt) m_lvl[i] = m_lvl[i] + 1;
                else if (tick && m_lvl[i] > tgt) m_lvl[i] = m_lvl[i] - 1;
            end
            x[3]  = any_diff;
            m_col = c;
            m_pwm = (m_pwm + 1) % (MAXL + 1);
            if (e) m_fc = (m_fc + 1) % FADE_DIV;
        end
        exp_q.push_back(x);
    endtask

    task automatic run(input bit r, input bit [2:0] c, input bit e, input int n);
        for (int k = 0; k < n; k++) step(r, c, e);
    endtask

    // Keep driving c until the model's channel ch reaches level v (bounded).
    task automatic run_until(input int ch, input int v, input bit [2:0] c);
        int k;
        k = 0;
        while (m_lvl[ch] != v && k < 200) begin
            step(1'b0, c, 1'b1);
            k++;
        end
        if (m_lvl[ch] != v) begin
            errors++;
            $display("FAIL run_until ch%0d level %0d required %0d", ch, m_lvl[ch], v);
        end
    endtask

    // Monitor: every edge the DUT presents a new output vector.
    initial begin
        logic [3:0] exp, act;
        forever begin
            @(posedge clk);
            #1;
            cycle++;
            if (exp_q.size() > 0) begin
                exp = exp_q.pop_front();
                act = {fading, blue, green, red};
                checks++;
                if (act !== exp) begin
                    errors++;
                    $display("FAIL outputs cycle %0d {fading,b,g,r} actual %b required %b",
                             cycle, act, exp);
                end
            end
        end
    end

    initial begin
        bit [2:0] c;
        bit e;
        for (int i = 0; i < 3; i++) m_lvl[i] = 0;
        m_col = 0; m_pwm = 0; m_fc = 0;

        $display("TXN reset hold colour=101, then release");
        run(1'b1, 3'b101, 1'b1, 3);
        run(1'b0, 3'b101, 1'b1, 40);

        $display("TXN fade-in red and steady duty");
        run(1'b1, COL_OFF, 1'b1, 1);
        run(1'b0, 3'b001, 1'b1, 64);

        $display("TXN reversal at red level 8");
        run(1'b1, COL_OFF, 1'b1, 1);
        run_until(RED_BIT, 8, 3'b001);
        run(1'b0, COL_OFF, 1'b1, 30);

        $display("TXN white then off");
        run(1'b1, COL_OFF, 1'b1, 1);
        run(1'b0, COL_WHITE, 1'b1, 40);
        run(1'b0, COL_OFF, 1'b1, 40);

        $display("TXN enable freeze at red level 5");
        run(1'b1, COL_OFF, 1'b1, 1);
        run_until(RED_BIT, 5, 3'b001);
        run(1'b0, 3'b001, 1'b0, 20);
        run(1'b0, 3'b001, 1'b1, 40);

        $display("TXN reset mid-fade at red level 10");
        run(1'b1, COL_OFF, 1'b1, 1);
        run_until(RED_BIT, 10, 3'b001);
        run(1'b1, 3'b001, 1'b1, 1);
        run(1'b0, 3'b001, 1'b1, 40);

        $display("TXN randomized colour/enable/reset traffic");
        c = 3'b000; e = 1'b1;
        for (int k = 0; k < 500; k++) begin
            if ($urandom_range(0, 19) == 0) c = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 29) == 0) e = ~e;
            step(($urandom_range(0, 199) == 0), c, e);
        end

        @(posedge clk);
        #3;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending %0d required 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_rgb_led_driver
